counter_ud_multi: RTL



---
 rtl/counter_ud_pkg.sv | 17 +
 rtl/counter_ud_multi_if.sv | 34 +++
 rtl/counter_ud_chan.sv | 102 ++++++++++
 rtl/counter_ud_multi.sv | 48 ++++
 4 files changed

// File: rtl/counter_ud_pkg.sv
// Shared types for the up/down counter bank.
// Mode encoding and intermediate-width helper.
package counter_ud_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Extra headroom bit so count + step never overflows.
  localparam int EXT_BITS = 1;

  function automatic int ext_width(input int w);
    return w + EXT_BITS;
  endfunction

endpackage

// File: rtl/counter_ud_multi_if.sv
// Signal bundle for the counter bank.
// master drives controls, slave drives status.
interface counter_ud_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       down;
  logic [CHANNELS-1:0]       mode_sat;
  logic [CHANNELS-1:0]       load_en;
  logic [CHANNELS*WIDTH-1:0] load_val;
  logic [CHANNELS*WIDTH-1:0] max_val;
  logic [CHANNELS*WIDTH-1:0] step;
  logic [CHANNELS-1:0]       clr_sticky;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       evt;
  logic [CHANNELS-1:0]       ovf_sticky;
  logic [CHANNELS-1:0]       at_max;
  logic [CHANNELS-1:0]       at_zero;

  modport master (
    output en, down, mode_sat, load_en,
    output load_val, max_val, step, clr_sticky,
    input  count, evt, ovf_sticky, at_max, at_zero
  );

  modport slave (
    input  en, down, mode_sat, load_en,
    input  load_val, max_val, step, clr_sticky,
    output count, evt, ovf_sticky, at_max, at_zero
  );

endinterface

// File: rtl/counter_ud_chan.sv
// One up/down counter channel: load, modulus, step,
// wrap/saturate, registered event and sticky flag.
module counter_ud_chan
  import counter_ud_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             down,
  input  logic             mode_sat,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [WIDTH-1:0] step,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] count,
  output logic             evt,
  output logic             ovf_sticky,
  output logic             at_max,
  output logic             at_zero
);

  localparam int XW = ext_width(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  cnt_mode_e mode;
  logic [WIDTH-1:0] s_w;
  logic [XW-1:0]    sum_x;
  logic [WIDTH-1:0] wrap_up;
  logic [WIDTH-1:0] wrap_dn;

  logic [WIDTH-1:0] count_q, count_d;
  logic             evt_q, evt_d;
  logic             sticky_q, sticky_d;

  assign mode  = cnt_mode_e'(mode_sat);
  assign s_w   = (step > max_val) ? max_val : step;
  assign sum_x = {1'b0, count_q} + {1'b0, s_w};
  // True results lie in 0..max_val, so modular
  // WIDTH-bit arithmetic gives the exact value.
  assign wrap_up = count_q + s_w - max_val - ONE;
  assign wrap_dn = count_q - s_w + max_val + ONE;

  always_comb begin
    count_d = count_q;
    evt_d   = 1'b0;
    if (load_en) begin
      count_d = (load_val > max_val) ? max_val
                                     : load_val;
    end else if (en) begin
      if (count_q > max_val) begin
        count_d = max_val;
      end else if (s_w == '0) begin
        count_d = count_q;
      end else if (!down) begin
        if (sum_x > {1'b0, max_val}) begin
          evt_d   = 1'b1;
          count_d = (mode == CNT_SAT) ? max_val
                                      : wrap_up;
        end else begin
          count_d = sum_x[WIDTH-1:0];
        end
      end else begin
        if (count_q >= s_w) begin
          count_d = count_q - s_w;
        end else begin
          evt_d   = 1'b1;
          count_d = (mode == CNT_SAT) ? '0
                                      : wrap_dn;
        end
      end
    end
  end

  // Set beats clear on a coincident edge.
  always_comb begin
    sticky_d = sticky_q;
    if (evt_d)           sticky_d = 1'b1;
    else if (clr_sticky) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q  <= '0;
      evt_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      evt_q    <= evt_d;
      sticky_q <= sticky_d;
    end
  end

  assign count      = count_q;
  assign evt        = evt_q;
  assign ovf_sticky = sticky_q;
  assign at_max     = (count_q == max_val);
  assign at_zero    = (count_q == '0);

endmodule

// File: rtl/counter_ud_multi.sv
// Bank of CHANNELS independent up/down counters.
// Flat per-channel vectors, channel i at [i*WIDTH +: WIDTH].
module counter_ud_multi
  import counter_ud_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       down,
  input  logic [CHANNELS-1:0]       mode_sat,
  input  logic [CHANNELS-1:0]       load_en,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic [CHANNELS*WIDTH-1:0] max_val,
  input  logic [CHANNELS*WIDTH-1:0] step,
  input  logic [CHANNELS-1:0]       clr_sticky,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       evt,
  output logic [CHANNELS-1:0]       ovf_sticky,
  output logic [CHANNELS-1:0]       at_max,
  output logic [CHANNELS-1:0]       at_zero
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    counter_ud_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en[i]),
      .down       (down[i]),
      .mode_sat   (mode_sat[i]),
      .load_en    (load_en[i]),
      .load_val   (load_val[i*WIDTH +: WIDTH]),
      .max_val    (max_val[i*WIDTH +: WIDTH]),
      .step       (step[i*WIDTH +: WIDTH]),
      .clr_sticky (clr_sticky[i]),
      .count      (count[i*WIDTH +: WIDTH]),
      .evt        (evt[i]),
      .ovf_sticky (ovf_sticky[i]),
      .at_max     (at_max[i]),
      .at_zero    (at_zero[i])
    );
  end

endmodule
